ex_muldiv_sequencer: RTL and testbench

- Iterative controller and datapath for RV32M MUL/DIV/REM instructions sitting in the Execution stage.
- Takes already-forwarded operands (same forwarding muxes as the ALU).
- Runs a radix-2 shift-add multiply or shift-subtract divide over XLEN cycles.
- Holds the front of the pipeline via stall until the result is ready, then hands the result to the EX/MEM register in place of the ALU result.

---
 rtl/ex_muldiv_sequencer.sv | 164 ++++++++++++++++
 tb/tb_ex_muldiv_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Radix-2 shift-add / shift-subtract over XLEN cycles, with a one-cycle sign fix-up.
module ex_muldiv_sequencer #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]      f3_q, f3_d;
    logic            neg_q, neg_d;
    logic            rneg_q, rneg_d;
    logic [XLEN-1:0] opnd_q, opnd_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            accept;
    logic            sgn_a, sgn_b, a_neg, b_neg;
    logic            div_zero, div_ovf, last_iter;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [XLEN:0]   mul_sum, rem_sh;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0] quot_fix, rem_fix;

    always_comb begin
        accept   = (state_q == S_IDLE) && start && !flush;
        sgn_a    = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
        sgn_b    = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        a_neg    = sgn_a && op_a[XLEN-1];
        b_neg    = sgn_b && op_b[XLEN-1];
        mag_a    = a_neg ? -op_a : op_a;
        mag_b    = b_neg ? -op_b : op_b;
        div_zero = funct3[2] && (op_b == '0);
        div_ovf  = funct3[2] && !funct3[0] &&
                   (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
        last_iter = (cnt_q == CNT_W'(XLEN-1));

        // hi_q/lo_q hold {product_hi, multiplier} for MUL and {remainder, quotient} for DIV
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh   = {hi_q, lo_q[XLEN-1]};
        prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        quot_fix = neg_q ? -lo_q : lo_q;
        rem_fix  = rneg_q ? -hi_q : hi_q;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        opnd_d   = opnd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    f3_d   = funct3;
                    cnt_d  = '0;
                    neg_d  = a_neg ^ b_neg;
                    rneg_d = a_neg;
                    opnd_d = mag_b;
                    hi_d   = '0;
                    lo_d   = mag_a;
                    if (div_zero) begin
                        result_d = funct3[1] ? op_a : '1;
                        state_d  = S_DONE;
                    end else if (div_ovf) begin
                        result_d = funct3[1] ? '0 : op_a;
                        state_d  = S_DONE;
                    end else begin
                        state_d = funct3[2] ? S_DIV : S_MUL;
                    end
                end
            end
            S_MUL: begin
                hi_d  = mul_sum[XLEN:1];
                lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) state_d = S_FIX;
            end
            S_DIV: begin
                if (rem_sh >= {1'b0, opnd_q}) begin
                    hi_d = XLEN'(rem_sh - {1'b0, opnd_q});
                    lo_d = {lo_q[XLEN-2:0], 1'b1};
                end else begin
                    hi_d = rem_sh[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) state_d = S_FIX;
            end
            S_FIX: begin
                case (f3_q)
                    3'b000:                 result_d = prod_fix[XLEN-1:0];
                    3'b001, 3'b010, 3'b011: result_d = prod_fix[2*XLEN-1:XLEN];
                    default:                result_d = f3_q[1] ? rem_fix : quot_fix;
                endcase
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // flush squashes the instruction: abandon the walk, leave result as it was
        if (flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
        end
    end

    assign stall  = reset && !flush &&
                    (((state_q == S_IDLE) && start) ||
                     (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX));
    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE) && !flush;
    assign result = result_q;

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Bench for ex_muldiv_sequencer: directed table, random ops against a 64-bit
// arithmetic reference, plus flush and mid-operation reset sequences.
module tb_ex_muldiv_sequencer;
    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_exp = '0;

    ex_muldiv_sequencer #(.XLEN(32), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .flush(flush),
        .stall(stall), .busy(busy), .done(done), .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    // Reference: exact 64-bit arithmetic with RISC-V corner-case rules
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        case (f)
            3'b000: begin p = ua * ub; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'b101: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 0) return 1;
        if ((f == 3'b100 || f == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Issues one op at the next negedge (cycle C0) and tracks stall/done per cycle.
    task automatic do_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat,
                         input bit hold_start, input bit post);
        int stall_cnt;
        int done_cyc;
        logic [31:0] res_at_done;
        stall_cnt   = 0;
        done_cyc    = -1;
        res_at_done = '0;
        @(negedge clk);
        start = 1'b1; funct3 = f; op_a = a; op_b = b;
        #1;
        for (int k = 0; k <= 60 && done_cyc < 0; k++) begin
            if (k > 0) begin
                @(negedge clk);
                if (k == 1 && !hold_start) start = 1'b0;
                #1;
            end
            if (stall) stall_cnt++;
            if (done) begin
                done_cyc    = k;
                res_at_done = result;
            end
        end
        start = 1'b0;
        chk({nm, " done_cycle"}, 32'(done_cyc), 32'(lat));
        chk({nm, " stall_cycles"}, 32'(stall_cnt), 32'(lat));
        chk({nm, " result"}, res_at_done, exp);
        last_exp = exp;
        if (post) begin
            @(negedge clk); #1;
            chk({nm, " done_pulse_end"}, {31'b0, done}, 32'd0);
            chk({nm, " result_held"}, result, exp);
        end
    endtask

    vec_t vecs[$];

    initial begin
        logic [2:0]  rf;
        logic [31:0] ra, rb;
        logic [31:0] corners [4];
        int          no_done;

        corners[0] = 32'h0; corners[1] = 32'h1;
        corners[2] = 32'hFFFF_FFFF; corners[3] = 32'h8000_0000;

        reset = 1'b1; start = 1'b0; flush = 1'b0;
        funct3 = '0; op_a = '0; op_b = '0;
        #2 reset = 1'b0;
        #1;
        chk("reset stall", {31'b0, stall}, 32'd0);
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset done", {31'b0, done}, 32'd0);
        chk("reset result", result, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        vecs.push_back('{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34});
        vecs.push_back('{3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34});
        vecs.push_back('{3'b011, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34});
        vecs.push_back('{3'b010, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 34});
        vecs.push_back('{3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34});
        vecs.push_back('{3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34});
        vecs.push_back('{3'b101, 32'd100,        32'd7,         32'd14,        34});
        vecs.push_back('{3'b111, 32'd100,        32'd7,         32'd2,         34});
        vecs.push_back('{3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, 1});
        vecs.push_back('{3'b110, 32'd5,          32'd0,         32'd5,         1});
        vecs.push_back('{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1});
        vecs.push_back('{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1});
        vecs.push_back('{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34});

        foreach (vecs[i])
            do_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b,
                  vecs[i].exp, vecs[i].lat, 1'b1, 1'b1);

        // back-to-back: second start arrives in the IDLE cycle right after DONE
        do_op("b2b_first", 3'b000, 32'd9, 32'd11, 32'd99, 34, 1'b1, 1'b0);
        do_op("b2b_second", 3'b101, 32'd99, 32'd9, 32'd11, 34, 1'b1, 1'b1);

        for (int i = 0; i < 40; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
            if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(0, 31);
            do_op($sformatf("rand%0d f3=%0d a=%h b=%h", i, rf, ra, rb), rf, ra, rb,
                  ref_model(rf, ra, rb), ref_lat(rf, ra, rb), 1'($urandom_range(0, 1)), 1'b1);
        end

        // flush in C10 of a divide
        no_done = 1;
        @(negedge clk);
        start = 1'b1; funct3 = 3'b101; op_a = 32'd1000; op_b = 32'd3;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk); #1;
            if (done) no_done = 0;
        end
        flush = 1'b1;
        #1;
        chk("flush stall_C10", {31'b0, stall}, 32'd0);
        chk("flush done_C10", {31'b0, done}, 32'd0);
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        #1;
        chk("flush busy_C11", {31'b0, busy}, 32'd0);
        chk("flush done_C11", {31'b0, done}, 32'd0);
        chk("flush no_early_done", 32'(no_done), 32'd1);
        chk("flush result_kept", result, last_exp);
        do_op("after_flush_mul", 3'b000, 32'd3, 32'd4, 32'd12, 34, 1'b1, 1'b1);

        // asynchronous reset in C20 of a multiply
        @(negedge clk);
        start = 1'b1; funct3 = 3'b000; op_a = 32'd5; op_b = 32'd6;
        for (int k = 1; k <= 20; k++) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("rst_mid stall", {31'b0, stall}, 32'd0);
        chk("rst_mid busy", {31'b0, busy}, 32'd0);
        chk("rst_mid done", {31'b0, done}, 32'd0);
        chk("rst_mid result", result, 32'd0);
        @(negedge clk);
        reset = 1'b1; start = 1'b0;
        no_done = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            if (done || busy) no_done = 0;
        end
        chk("rst_mid no_pending_done", 32'(no_done), 32'd1);
        do_op("after_reset_mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'hFFFF_FFFE, 34, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
